// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types and sizing constants.
package cpu_types_pkg;

    localparam int NUM_ARCH_REGS   = 32;
    localparam int SB_MAX_INFLIGHT = 4;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// Up/down saturating counter with synchronous clear; err flags a step past either bound.
module sb_counter #(
    parameter  int MAX = 4,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          err
);

    localparam logic [CW-1:0] CMAX = CW'(MAX);

    // Simultaneous inc and dec cancel; a step past a bound holds the count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !dec && count != CMAX) begin
            count <= count + CW'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign err = (dec && count == '0) || (inc && count == CMAX);

endmodule

// File: rtl/pipeline_scoreboard.sv
// Issue scoreboard: tracks pending destination writes between IDU issue and WBU retire.
module pipeline_scoreboard
    import cpu_types_pkg::*;
#(
    parameter  int NUM_REGS     = NUM_ARCH_REGS,
    parameter  int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    localparam int IW           = $clog2(NUM_REGS),
    localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [IW-1:0] id_rs1,
    input  logic [IW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [IW-1:0] id_rd,
    input  logic          id_rd_wen,
    output logic          id_stall,
    input  logic          id_fire,
    input  logic          wb_valid,
    input  logic [IW-1:0] wb_rd,
    input  logic          wb_wen,
    input  logic          redirect_valid,
    output logic          busy,
    output logic          sb_err
);

    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0] pend_nz;
    logic [NUM_REGS-1:0] pend_err;
    logic [CW-1:0]       inflight;
    logic                inflight_err;
    logic                haz;
    logic                full;

    // x0 is never tracked, so its slot reads as permanently clear.
    assign pend_nz[0]  = 1'b0;
    assign pend_err[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
        logic [CW-1:0] cnt;

        sb_counter #(.MAX(MAX_INFLIGHT)) u_pend (
            .clk   (clk),
            .rst   (rst),
            .inc   (id_fire && id_rd_wen && id_rd == IW'(r)),
            .dec   (wb_valid && wb_wen && wb_rd == IW'(r)),
            .clr   (redirect_valid),
            .count (cnt),
            .err   (pend_err[r])
        );

        assign pend_nz[r] = (cnt != '0);
    end

    sb_counter #(.MAX(MAX_INFLIGHT)) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_fire),
        .dec   (wb_valid),
        .clr   (redirect_valid),
        .count (inflight),
        .err   (inflight_err)
    );

    // Hazard looks only at registered counts; a same-cycle retire does not unstall.
    assign haz      = (id_rs1_used && pend_nz[id_rs1]) || (id_rs2_used && pend_nz[id_rs2]);
    assign full     = (inflight == FULL_CNT);
    assign id_stall = id_valid && (haz || full || redirect_valid);
    assign busy     = (inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if ((|pend_err) || inflight_err || (id_fire && id_stall)) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: RAW, x0, full window, simultaneous, WAW, redirect, errors.
module tb_pipeline_scoreboard;
    import cpu_types_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     id_valid;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;
    logic     id_rs1_used;
    logic     id_rs2_used;
    reg_idx_t id_rd;
    logic     id_rd_wen;
    logic     id_stall;
    logic     id_fire;
    logic     wb_valid;
    reg_idx_t wb_rd;
    logic     wb_wen;
    logic     redirect_valid;
    logic     busy;
    logic     sb_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_rd_wen      (id_rd_wen),
        .id_stall       (id_stall),
        .id_fire        (id_fire),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_wen         (wb_wen),
        .redirect_valid (redirect_valid),
        .busy           (busy),
        .sb_err         (sb_err)
    );

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_wen = 0; id_fire = 0;
        wb_valid = 0; wb_rd = 0; wb_wen = 0; redirect_valid = 0;
    endtask

    // Advance one edge, then settle inputs 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic issue(input int rd, input logic wen);
        id_valid = 1; id_rd = reg_idx_t'(rd); id_rd_wen = wen; id_fire = 1;
    endtask

    task automatic retire(input int rd, input logic wen);
        wb_valid = 1; wb_rd = reg_idx_t'(rd); wb_wen = wen;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", id_stall, 1'b0);
        chk("rst_err", sb_err, 1'b0);
        id_valid = 1; redirect_valid = 1; #1;
        chk("rst_redir_stall", id_stall, 1'b1);
        idle(); #1;

        // RAW on x5
        issue(5, 1); #1;
        chk("raw_issue_ok", id_stall, 1'b0);
        tick();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; #1;
        chk("raw_stall", id_stall, 1'b1);
        chk("raw_busy", busy, 1'b1);
        tick();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; retire(5, 1); #1;
        chk("raw_no_bypass", id_stall, 1'b1);
        tick();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; #1;
        chk("raw_clear", id_stall, 1'b0);
        chk("raw_idle", busy, 1'b0);
        id_fire = 1;
        tick();
        retire(0, 0);
        tick();

        // x0 destination and sources
        issue(0, 1); #1;
        chk("x0_issue", id_stall, 1'b0);
        tick();
        id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1; #1;
        chk("x0_src", id_stall, 1'b0);
        id_fire = 1;
        tick();
        retire(0, 1); tick();
        retire(0, 0); tick();
        chk("x0_drained", busy, 1'b0);

        // Full window
        for (int i = 0; i < 4; i++) begin
            issue(10 + i, 1); #1;
            chk("full_fill", id_stall, 1'b0);
            tick();
        end
        id_valid = 1; id_rd = 14; id_rd_wen = 1; #1;
        chk("full_stall", id_stall, 1'b1);
        chk("full_busy", busy, 1'b1);
        tick();
        id_valid = 1; id_rd = 14; id_rd_wen = 1; retire(10, 1); #1;
        chk("full_still", id_stall, 1'b1);
        tick();
        id_valid = 1; id_rd = 14; id_rd_wen = 1; #1;
        chk("full_unstall", id_stall, 1'b0);
        chk("full_busy2", busy, 1'b1);
        id_fire = 1;
        tick();
        for (int i = 11; i <= 14; i++) begin
            chk("full_drain_busy", busy, 1'b1);
            retire(i, 1); tick();
        end
        chk("full_empty", busy, 1'b0);

        // Simultaneous issue and retire of x7
        issue(7, 1); tick();
        issue(7, 1); retire(7, 1); #1;
        chk("simul_issue_ok", id_stall, 1'b0);
        tick();
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; #1;
        chk("simul_p7", id_stall, 1'b1);
        chk("simul_busy", busy, 1'b1);
        tick();
        retire(7, 1); tick();
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; #1;
        chk("simul_clear", id_stall, 1'b0);
        idle(); #1;

        // WAW on x3
        issue(3, 1); tick();
        issue(3, 1); #1;
        chk("waw_issue", id_stall, 1'b0);
        tick();
        retire(3, 1); tick();
        id_valid = 1; id_rs1 = 3; id_rs1_used = 1; #1;
        chk("waw_one_left", id_stall, 1'b1);
        retire(3, 1);
        tick();
        id_valid = 1; id_rs1 = 3; id_rs1_used = 1; #1;
        chk("waw_clear", id_stall, 1'b0);
        chk("waw_idle", busy, 1'b0);
        idle(); #1;

        // Redirect with three in flight
        for (int i = 20; i < 23; i++) begin
            issue(i, 1); tick();
        end
        id_valid = 1; redirect_valid = 1; retire(20, 0); #1;
        chk("redir_stall", id_stall, 1'b1);
        tick();
        id_valid = 1; id_rs1 = 21; id_rs1_used = 1; id_rs2 = 22; id_rs2_used = 1; #1;
        chk("redir_clear", id_stall, 1'b0);
        chk("redir_busy", busy, 1'b0);
        chk("redir_no_err", sb_err, 1'b0);
        idle(); #1;

        // Retire with nothing in flight
        retire(0, 0); tick();
        chk("err_set", sb_err, 1'b1);
        chk("err_no_wrap", busy, 1'b0);
        tick(); tick();
        chk("err_sticky", sb_err, 1'b1);
        rst = 1;
        tick();
        rst = 0; #1;
        chk("err_rst", sb_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
